mastermind_score_core: RTL and testbench

//   Parametrised Mastermind/Wordle game core. It latches a secret code, collects a guess one colour per Enter pulse,
//   and scores each guess sequentially with exact (right colour, right slot) and partial (right colour, wrong slot) counts.
//   It tracks the guess count and ends in WIN or LOSE. It sits below the board top: Enter/Del/Start/Ack come from debouncer SCEN pulses.

---
 rtl/mastermind_score_core.sv | 213 +++++++++++++++++++++
 tb/tb_mastermind_score_core.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mastermind_score_core.sv
// Mastermind/Wordle scoring core: latches a secret, collects a guess slot by slot, then
// scores it sequentially (exact pass, then duplicate-safe partial pass) and tracks WIN/LOSE.
module mastermind_score_core #(
  parameter int N_SLOTS     = 4,
  parameter int COLOR_W     = 6,
  parameter int MAX_GUESSES = 6,
  localparam int CW = $clog2(N_SLOTS + 1),
  localparam int GW = $clog2(MAX_GUESSES + 1),
  localparam int SW = $clog2(N_SLOTS)
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       Start,
  input  logic [N_SLOTS*COLOR_W-1:0] Secret,
  input  logic                       Enter,
  input  logic                       Del,
  input  logic [COLOR_W-1:0]         ColorIn,
  input  logic                       Ack,
  output logic [2:0]                 State,
  output logic [SW:0]                SlotIdx,
  output logic [GW-1:0]              GuessNum,
  output logic [CW-1:0]              Exact,
  output logic [CW-1:0]              Partial,
  output logic                       ScoreValid,
  output logic                       Done
);

  typedef enum logic [2:0] {
    ST_INI    = 3'd0,
    ST_ENTRY  = 3'd1,
    ST_EXACT  = 3'd2,
    ST_PART   = 3'd3,
    ST_RESULT = 3'd4,
    ST_WIN    = 3'd5,
    ST_LOSE   = 3'd6
  } state_t;

  localparam logic [SW:0]   LAST_SLOT = (SW+1)'(N_SLOTS - 1);
  localparam logic [SW-1:0] IDX_LAST  = SW'(N_SLOTS - 1);
  localparam logic [CW-1:0] EX_FULL   = CW'(N_SLOTS);
  localparam logic [GW-1:0] GN_MAX    = GW'(MAX_GUESSES);

  state_t               state_q, state_d;
  logic [COLOR_W-1:0]   secret_q [N_SLOTS];
  logic [COLOR_W-1:0]   secret_d [N_SLOTS];
  logic [COLOR_W-1:0]   guess_q  [N_SLOTS];
  logic [COLOR_W-1:0]   guess_d  [N_SLOTS];
  logic [N_SLOTS-1:0]   gflag_q, gflag_d, sflag_q, sflag_d;
  logic [SW:0]          slot_q, slot_d;
  logic [SW-1:0]        i_q, i_d, j_q, j_d;
  logic [CW-1:0]        ex_q, ex_d, pa_q, pa_d;
  logic [CW-1:0]        exact_q, exact_d, partial_q, partial_d;
  logic [GW-1:0]        gnum_q, gnum_d, gnum_inc;
  logic                 sv_q, sv_d, done_q, done_d;
  logic                 exact_hit, part_hit;

  assign exact_hit = (guess_q[i_q] == secret_q[i_q]);
  // A pair only counts if neither side was already consumed by an exact or earlier partial match.
  assign part_hit  = !gflag_q[i_q] && !sflag_q[j_q] && (guess_q[i_q] == secret_q[j_q]);
  assign gnum_inc  = gnum_q + GW'(1);

  always_comb begin
    state_d   = state_q;
    secret_d  = secret_q;
    guess_d   = guess_q;
    gflag_d   = gflag_q;
    sflag_d   = sflag_q;
    slot_d    = slot_q;
    i_d       = i_q;
    j_d       = j_q;
    ex_d      = ex_q;
    pa_d      = pa_q;
    exact_d   = exact_q;
    partial_d = partial_q;
    gnum_d    = gnum_q;
    sv_d      = 1'b0;
    done_d    = done_q;
    case (state_q)
      ST_INI: begin
        if (Start) begin
          for (int k = 0; k < N_SLOTS; k++) secret_d[k] = Secret[k*COLOR_W +: COLOR_W];
          gnum_d    = '0;
          slot_d    = '0;
          exact_d   = '0;
          partial_d = '0;
          state_d   = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (Enter) begin
          guess_d[slot_q[SW-1:0]] = ColorIn;
          slot_d = slot_q + (SW+1)'(1);
          if (slot_q == LAST_SLOT) begin
            state_d = ST_EXACT;
            i_d     = '0;
            ex_d    = '0;
            pa_d    = '0;
            gflag_d = '0;
            sflag_d = '0;
          end
        end else if (Del && slot_q != '0) begin
          slot_d = slot_q - (SW+1)'(1);
        end
      end
      ST_EXACT: begin
        if (exact_hit) begin
          ex_d        = ex_q + CW'(1);
          gflag_d[i_q] = 1'b1;
          sflag_d[i_q] = 1'b1;
        end
        if (i_q == IDX_LAST) begin
          state_d = ST_PART;
          i_d     = '0;
          j_d     = '0;
        end else begin
          i_d = i_q + SW'(1);
        end
      end
      ST_PART: begin
        if (part_hit) begin
          pa_d         = pa_q + CW'(1);
          gflag_d[i_q] = 1'b1;
          sflag_d[j_q] = 1'b1;
        end
        if (j_q != IDX_LAST) begin
          j_d = j_q + SW'(1);
        end else begin
          j_d = '0;
          if (i_q != IDX_LAST) begin
            i_d = i_q + SW'(1);
          end else begin
            // Last pair: publish results on this same edge so latency is N+N^2.
            exact_d   = ex_q;
            partial_d = pa_d;
            gnum_d    = gnum_inc;
            sv_d      = 1'b1;
            if (ex_q == EX_FULL) begin
              state_d = ST_WIN;
              done_d  = 1'b1;
            end else if (gnum_inc == GN_MAX) begin
              state_d = ST_LOSE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RESULT;
            end
          end
        end
      end
      ST_RESULT: begin
        if (Enter) begin
          slot_d  = '0;
          gflag_d = '0;
          sflag_d = '0;
          state_d = ST_ENTRY;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (Ack) begin
          done_d  = 1'b0;
          state_d = ST_INI;
        end
      end
      default: state_d = ST_INI;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_INI;
      for (int k = 0; k < N_SLOTS; k++) begin
        secret_q[k] <= '0;
        guess_q[k]  <= '0;
      end
      gflag_q   <= '0;
      sflag_q   <= '0;
      slot_q    <= '0;
      i_q       <= '0;
      j_q       <= '0;
      ex_q      <= '0;
      pa_q      <= '0;
      exact_q   <= '0;
      partial_q <= '0;
      gnum_q    <= '0;
      sv_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      secret_q  <= secret_d;
      guess_q   <= guess_d;
      gflag_q   <= gflag_d;
      sflag_q   <= sflag_d;
      slot_q    <= slot_d;
      i_q       <= i_d;
      j_q       <= j_d;
      ex_q      <= ex_d;
      pa_q      <= pa_d;
      exact_q   <= exact_d;
      partial_q <= partial_d;
      gnum_q    <= gnum_d;
      sv_q      <= sv_d;
      done_q    <= done_d;
    end
  end

  assign State      = state_q;
  assign SlotIdx    = slot_q;
  assign GuessNum   = gnum_q;
  assign Exact      = exact_q;
  assign Partial    = partial_q;
  assign ScoreValid = sv_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_mastermind_score_core.sv
// Directed + randomized bench for mastermind_score_core; scores are predicted by a
// multiset-intersection reference model.
module tb_mastermind_score_core;
  localparam int N  = 4;
  localparam int W  = 6;
  localparam int MG = 6;

  logic           CLK = 1'b0;
  logic           RESET_N = 1'b0;
  logic           Start = 1'b0, Enter = 1'b0, Del = 1'b0, Ack = 1'b0;
  logic [N*W-1:0] Secret = '0;
  logic [W-1:0]   ColorIn = '0;
  logic [2:0]     State, SlotIdx, GuessNum, Exact, Partial;
  logic           ScoreValid, Done;

  int checks = 0;
  int errors = 0;
  int sec_m[N];
  int g_m[N];
  int gnum_m = 0;
  int state_m = 0;

  mastermind_score_core #(.N_SLOTS(N), .COLOR_W(W), .MAX_GUESSES(MG)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .Start(Start), .Secret(Secret), .Enter(Enter),
    .Del(Del), .ColorIn(ColorIn), .Ack(Ack), .State(State), .SlotIdx(SlotIdx),
    .GuessNum(GuessNum), .Exact(Exact), .Partial(Partial), .ScoreValid(ScoreValid),
    .Done(Done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Total colour matches = size of the multiset intersection; partial = total - exact.
  function automatic void ref_score(output int ex, output int pa);
    int pool[$];
    int tot;
    ex = 0;
    tot = 0;
    for (int k = 0; k < N; k++) begin
      if (sec_m[k] == g_m[k]) ex++;
      pool.push_back(sec_m[k]);
    end
    for (int k = 0; k < N; k++) begin
      int idx[$];
      idx = pool.find_first_index with (item == g_m[k]);
      if (idx.size() > 0) begin
        pool.delete(idx[0]);
        tot++;
      end
    end
    pa = tot - ex;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic enter_c(input int c);
    ColorIn = W'(c);
    Enter = 1'b1;
    step();
    Enter = 1'b0;
  endtask

  task automatic del_p();
    Del = 1'b1;
    step();
    Del = 1'b0;
  endtask

  task automatic ack_p();
    Ack = 1'b1;
    step();
    Ack = 1'b0;
  endtask

  task automatic new_game();
    for (int k = 0; k < N; k++) Secret[k*W +: W] = W'(sec_m[k]);
    Start = 1'b1;
    step();
    Start = 1'b0;
    Secret = '0;
    gnum_m = 0;
    check("start_state", State, 1);
    check("start_guessnum", GuessNum, 0);
    check("start_slot", SlotIdx, 0);
  endtask

  task automatic leave_result();
    if (State == 3'd4) begin
      ColorIn = W'($urandom_range(0, 63));
      enter_c(int'(ColorIn));
      check("result_to_entry", State, 1);
      check("result_slot_clr", SlotIdx, 0);
    end
  endtask

  // Waits for the score of g_m and compares it with the model; inject drives all control pulses
  // during the first scoring cycles, which must be ignored.
  task automatic finish_guess(input bit inject);
    int ex, pa, lat;
    ref_score(ex, pa);
    gnum_m++;
    state_m = (ex == N) ? 5 : (gnum_m == MG) ? 6 : 4;
    check("in_exact", State, 2);
    check("slot_full", SlotIdx, N);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (inject && n <= 3) begin
        Enter = 1'b1; Del = 1'b1; Start = 1'b1; Ack = 1'b1;
        ColorIn = W'($urandom_range(0, 63));
      end
      step();
      Enter = 1'b0; Del = 1'b0; Start = 1'b0; Ack = 1'b0;
      if (ScoreValid) begin
        lat = n;
        break;
      end
    end
    check("latency", lat, N + N * N);
    check("exact", Exact, ex);
    check("partial", Partial, pa);
    check("guessnum", GuessNum, gnum_m);
    check("state", State, state_m);
    check("done", Done, (state_m >= 5) ? 1 : 0);
    step();
    check("sv_pulse", ScoreValid, 0);
    check("exact_hold", Exact, ex);
  endtask

  task automatic play_guess(input bit inject);
    for (int k = 0; k < N; k++) begin
      enter_c(g_m[k]);
      if (k < N - 1) check("slot_inc", SlotIdx, k + 1);
    end
    finish_guess(inject);
  endtask

  initial begin
    int sv_seen;
    RESET_N = 1'b0;
    repeat (3) step();
    check("rst_state", State, 0);
    check("rst_slot", SlotIdx, 0);
    check("rst_gnum", GuessNum, 0);
    check("rst_exact", Exact, 0);
    check("rst_partial", Partial, 0);
    check("rst_sv", ScoreValid, 0);
    check("rst_done", Done, 0);
    RESET_N = 1'b1;
    step();
    // Inputs other than Start are ignored in INI.
    enter_c(3);
    check("ini_ignore", State, 0);

    // Secret {1,2,3,4}: reversed guess with ignored pulses, then a winning guess.
    sec_m = '{1, 2, 3, 4};
    new_game();
    g_m = '{4, 3, 2, 1};
    play_guess(1'b1);
    check("rev_partial4", Partial, 4);
    check("rev_result", State, 4);
    leave_result();
    g_m = '{1, 2, 3, 4};
    play_guess(1'b0);
    check("win_state", State, 5);
    step();
    check("win_hold", State, 5);
    ack_p();
    check("ack_ini", State, 0);
    check("ack_done", Done, 0);
    check("ack_gnum_hold", GuessNum, 2);
    check("ack_exact_hold", Exact, 4);

    // Duplicate handling, then reset in the middle of the partial pass.
    sec_m = '{1, 1, 2, 2};
    new_game();
    g_m = '{1, 2, 1, 1};
    play_guess(1'b0);
    check("dup_exact1", Exact, 1);
    check("dup_partial2", Partial, 2);
    leave_result();
    for (int k = 0; k < N; k++) enter_c(g_m[k]);
    repeat (N + 3) step();
    check("mid_in_part", State, 3);
    RESET_N = 1'b0;
    #1;
    check("mid_rst_state", State, 0);
    check("mid_rst_exact", Exact, 0);
    check("mid_rst_partial", Partial, 0);
    check("mid_rst_gnum", GuessNum, 0);
    check("mid_rst_slot", SlotIdx, 0);
    check("mid_rst_sv", ScoreValid, 0);
    repeat (2) step();
    RESET_N = 1'b1;
    sv_seen = 0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (ScoreValid) sv_seen++;
    end
    check("mid_no_score", sv_seen, 0);
    check("mid_stay_ini", State, 0);

    // Entry editing: Del at 0 ignored, Del drops last slot, Enter wins over Del.
    sec_m = '{5, 9, 9, 9};
    new_game();
    del_p();
    check("del_at0", SlotIdx, 0);
    enter_c(5);
    enter_c(7);
    del_p();
    check("del_slot", SlotIdx, 1);
    ColorIn = 6'd9; Enter = 1'b1; Del = 1'b1;
    step();
    Enter = 1'b0; Del = 1'b0;
    check("enter_wins", SlotIdx, 2);
    enter_c(9);
    enter_c(9);
    g_m = '{5, 9, 9, 9};
    finish_guess(1'b0);
    check("edit_win", State, 5);
    ack_p();

    // Six wrong guesses end in LOSE.
    sec_m = '{1, 2, 3, 4};
    new_game();
    g_m = '{0, 0, 0, 0};
    for (int r = 0; r < MG; r++) begin
      leave_result();
      play_guess(1'b0);
    end
    check("lose_state", State, 6);
    check("lose_gnum", GuessNum, 6);
    ack_p();
    check("lose_ack", State, 0);

    // Randomized games with a small colour alphabet to exercise duplicates.
    for (int gm = 0; gm < 8; gm++) begin
      for (int k = 0; k < N; k++) sec_m[k] = $urandom_range(0, 3);
      new_game();
      for (int r = 0; r < MG; r++) begin
        leave_result();
        if ($urandom_range(0, 5) == 0) g_m = sec_m;
        else for (int k = 0; k < N; k++) g_m[k] = $urandom_range(0, 3);
        play_guess($urandom_range(0, 1) == 1);
        if (State != 3'd4) break;
      end
      ack_p();
      check("rand_ack", State, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
